hazard_monitor: RTL and testbench

Multi-zone successor to the single-zone gas/smoke/humidity/temperature hazard classifier. Each zone's four raw sensor inputs are synchronised and debounced, then classified into green/yellow/red using the team's established hazard equations. A per-zone state machine latches red alarms until operator acknowledge and drives a shared buzzer. Sits between the sensor input pins and the zone LED panel and buzzer driver.

---
 rtl/hazard_monitor.sv | 84 ++++++++
 tb/tb_hazard_monitor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/hazard_monitor.sv
// hazard_monitor: per-zone sensor sync/debounce, green/yellow/red hazard classing,
// alarm latching until acknowledge, and a shared buzzer.
module hazard_monitor #(
  parameter int N_ZONES = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_ZONES-1:0] sensor_gas,
  input  logic [N_ZONES-1:0] sensor_smoke,
  input  logic [N_ZONES-1:0] sensor_hum,
  input  logic [N_ZONES-1:0] sensor_temp,
  input  logic [N_ZONES-1:0] ack,
  output logic [N_ZONES-1:0] led_red,
  output logic [N_ZONES-1:0] led_yellow,
  output logic [N_ZONES-1:0] led_green,
  output logic               buzzer
);
  localparam int NB = 4 * N_ZONES;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {SAFE, WARN, ALARM, SILENCED} state_t;
  logic [NB-1:0] raw, s1, s2, filt;
  logic [CW-1:0] cnt [NB];
  logic [N_ZONES-1:0] g, s, h, t, red, yellow, alarm_nxt;
  state_t state [N_ZONES];
  state_t nxt [N_ZONES];
  assign raw = {sensor_temp, sensor_hum, sensor_smoke, sensor_gas};
  assign {t, h, s, g} = filt;
  assign red = t & (s | g);
  assign yellow = (~g & ~s & t) | (s & h & ~t) | (g & ~t);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end
  // a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (s2[i] == filt[i]) cnt[i] <= '0;
        else if (cnt[i] == LAST) begin
          filt[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  always_comb begin
    for (int z = 0; z < N_ZONES; z++) begin
      nxt[z] = state[z];
      case (state[z])
        ALARM:    if (ack[z]) nxt[z] = red[z] ? SILENCED : yellow[z] ? WARN : SAFE;
        SILENCED: nxt[z] = red[z] ? SILENCED : yellow[z] ? WARN : SAFE;
        default:  nxt[z] = red[z] ? ALARM : yellow[z] ? WARN : SAFE;
      endcase
      alarm_nxt[z] = nxt[z] == ALARM;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < N_ZONES; z++) state[z] <= SAFE;
      led_green <= '1;
      led_yellow <= '0;
      led_red <= '0;
      buzzer <= 1'b0;
    end else begin
      for (int z = 0; z < N_ZONES; z++) begin
        state[z] <= nxt[z];
        led_green[z] <= nxt[z] == SAFE;
        led_yellow[z] <= nxt[z] == WARN;
        led_red[z] <= nxt[z] == ALARM || nxt[z] == SILENCED;
      end
      buzzer <= |alarm_nxt;
    end
  end
endmodule

// File: tb/tb_hazard_monitor.sv
// tb_hazard_monitor: directed scenarios with a behavioural zone model checked every cycle.
module tb_hazard_monitor;
  localparam int N = 4, DB = 8;
  logic clk = 0, rst_n = 0, chk_on = 0;
  logic [N-1:0] gas = 0, smoke = 0, hum = 0, temp = 0, ack = 0;
  logic [N-1:0] led_red, led_yellow, led_green;
  logic buzzer;
  int checks = 0, failures = 0;

  hazard_monitor #(.N_ZONES(N), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sensor_gas(gas), .sensor_smoke(smoke),
    .sensor_hum(hum), .sensor_temp(temp), .ack(ack), .led_red(led_red),
    .led_yellow(led_yellow), .led_green(led_green), .buzzer(buzzer));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // model: sensor bits delayed two edges, a bit flips once its last DB samples all
  // disagree with it; zone state 0=safe 1=warn 2=alarm 3=silenced
  logic [4*N-1:0] m_s1, m_s2, m_filt;
  logic [DB-1:0] m_hist [4*N];
  int m_st [N];
  int mc;

  function automatic int cls(input logic g, input logic s, input logic h, input logic t);
    if (t) return (g || s) ? 2 : 1;
    if (g) return 1;
    return (s && h) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0;
      m_s2 <= '0;
      m_filt <= '0;
      for (int b = 0; b < 4*N; b++) m_hist[b] <= '0;
      for (int z = 0; z < N; z++) m_st[z] <= 0;
    end else begin
      m_s1 <= {temp, hum, smoke, gas};
      m_s2 <= m_s1;
      for (int b = 0; b < 4*N; b++) begin
        m_hist[b] <= {m_hist[b][DB-2:0], m_s2[b]};
        if ({m_hist[b][DB-2:0], m_s2[b]} == {DB{~m_filt[b]}}) m_filt[b] <= ~m_filt[b];
      end
      for (int z = 0; z < N; z++) begin
        mc = cls(m_filt[z], m_filt[N+z], m_filt[2*N+z], m_filt[3*N+z]);
        case (m_st[z])
          2: if (ack[z]) m_st[z] <= (mc == 2) ? 3 : mc;
          3: m_st[z] <= (mc == 2) ? 3 : mc;
          default: m_st[z] <= (mc == 2) ? 2 : mc;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [N-1:0] eg, ey, er;
      logic eb;
      eb = 0;
      for (int z = 0; z < N; z++) begin
        eg[z] = m_st[z] == 0;
        ey[z] = m_st[z] == 1;
        er[z] = m_st[z] >= 2;
        eb = eb | (m_st[z] == 2);
      end
      check("model_green", led_green, eg);
      check("model_yellow", led_yellow, ey);
      check("model_red", led_red, er);
      check("model_buzzer", {{(N-1){1'b0}}, buzzer}, {{(N-1){1'b0}}, eb});
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_on = 1;
    rst_n = 1;
    repeat (5) @(negedge clk);
    check("idle_green", led_green, 4'b1111);
    check("idle_red", led_red, 4'b0000);
    check("idle_buzzer", buzzer, 0);
    // zone 2: T&S is red, visible exactly 11 edges after first sampling edge
    temp[2] = 1; smoke[2] = 1;
    repeat (10) @(posedge clk);
    #1 check("z2_red_edge10", led_red[2], 0);
    @(posedge clk);
    #1 check("z2_red_edge11", led_red[2], 1);
    check("z2_buzzer", buzzer, 1);
    check("z2_others_green", led_green, 4'b1011);
    @(negedge clk);
    temp[2] = 0; smoke[2] = 0;
    repeat (15) @(negedge clk);
    check("z2_latched", led_red[2], 1);
    check("z2_latched_buzzer", buzzer, 1);
    ack[2] = 1;
    @(posedge clk);
    #1 check("z2_ack_green", led_green[2], 1);
    check("z2_ack_buzzer", buzzer, 0);
    @(negedge clk);
    ack[2] = 0;
    // zone 0: G&T alarm, silence, yellow via G&~T, re-alarm
    gas[0] = 1; temp[0] = 1;
    repeat (12) @(negedge clk);
    check("z0_alarm", led_red[0], 1);
    check("z0_alarm_buzzer", buzzer, 1);
    ack[0] = 1;
    @(negedge clk);
    ack[0] = 0;
    check("z0_silenced_red", led_red[0], 1);
    check("z0_silenced_buzzer", buzzer, 0);
    temp[0] = 0;
    repeat (12) @(negedge clk);
    check("z0_yellow", led_yellow, 4'b0001);
    temp[0] = 1;
    repeat (12) @(negedge clk);
    check("z0_realarm", led_red[0], 1);
    check("z0_realarm_buzzer", buzzer, 1);
    gas[0] = 0; temp[0] = 0;
    repeat (12) @(negedge clk);
    ack[0] = 1;
    @(negedge clk);
    ack[0] = 0;
    check("z0_cleared", led_green, 4'b1111);
    // zone 1: 7-cycle glitch is filtered, 8-cycle pulse passes
    temp[1] = 1;
    repeat (7) @(negedge clk);
    temp[1] = 0;
    repeat (15) @(negedge clk);
    check("z1_glitch_green", led_green, 4'b1111);
    temp[1] = 1;
    repeat (8) @(negedge clk);
    temp[1] = 0;
    repeat (2) @(posedge clk);
    #1 check("z1_pulse_edge10", led_yellow[1], 0);
    @(posedge clk);
    #1 check("z1_pulse_edge11", led_yellow[1], 1);
    repeat (12) @(negedge clk);
    check("z1_release_green", led_green[1], 1);
    // zone 3: async reset mid-alarm, then re-alarm with inputs still held
    gas[3] = 1; temp[3] = 1;
    repeat (12) @(negedge clk);
    check("z3_alarm", led_red[3], 1);
    @(posedge clk);
    #3 rst_n = 0;
    #1 check("rst_green", led_green, 4'b1111);
    check("rst_red", led_red, 4'b0000);
    check("rst_yellow", led_yellow, 4'b0000);
    check("rst_buzzer", buzzer, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (10) @(posedge clk);
    #1 check("z3_rearm_edge10", led_red[3], 0);
    @(posedge clk);
    #1 check("z3_rearm_edge11", led_red[3], 1);
    check("z3_rearm_buzzer", buzzer, 1);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
